// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: raw paddle buttons -> synchronised, debounced, auto-repeating steps -> clamped paddle Y
//   clk       system clock
//   rst       synchronous active-high reset
//   btn_raw   async button levels {p2_dn, p2_up, p1_dn, p1_up}
//   enable    1 = movement allowed; 0 parks every press FSM in IDLE
//   recenter  1-cycle pulse, both paddles to CENTER
//   btn_db    debounced levels, same bit order as btn_raw
//   step      1-cycle step pulses, same bit order as btn_raw
//   p1_y      player-1 paddle top Y
//   p2_y      player-2 paddle top Y
module paddle_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int HOLD_CYCLES     = 19500000,
    parameter int REPEAT_CYCLES   = 1300000,
    parameter int STEP            = 8,
    parameter int Y_MAX           = 768,
    parameter int PADDLE_H        = 96,
    parameter int Y_W             = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     btn_raw,
    input  logic           enable,
    input  logic           recenter,
    output logic [3:0]     btn_db,
    output logic [3:0]     step,
    output logic [Y_W-1:0] p1_y,
    output logic [Y_W-1:0] p2_y
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int T_W  = $clog2(TMAX + 1);
    localparam logic [Y_W-1:0] Y_TOP  = Y_W'(Y_MAX - PADDLE_H);
    localparam logic [Y_W-1:0] CENTER = Y_W'((Y_MAX - PADDLE_H) / 2);
    localparam logic [Y_W-1:0] STEP_Y = Y_W'(STEP);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [3:0] s1, s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic [DB_W-1:0] cnt;
        logic [T_W-1:0]  tmr;
        state_t          st;
        logic            db, stp;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                db  <= 1'b0;
                tmr <= '0;
                st  <= IDLE;
                stp <= 1'b0;
            end else begin
                if (s2[i] == db)
                    cnt <= '0;
                else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db  <= ~db;
                    cnt <= '0;
                end else
                    cnt <= cnt + 1'b1;
                stp <= 1'b0;
                if (!enable)
                    st <= IDLE;
                else
                    case (st)
                        IDLE: if (db) begin
                            stp <= 1'b1;
                            tmr <= T_W'(HOLD_CYCLES - 1);
                            st  <= HOLD;
                        end
                        HOLD, REPEAT: if (!db)
                            st <= IDLE;
                        else if (tmr == '0) begin
                            stp <= 1'b1;
                            tmr <= T_W'(REPEAT_CYCLES - 1);
                            st  <= REPEAT;
                        end else
                            tmr <= tmr - 1'b1;
                        default: st <= IDLE;
                    endcase
            end
        end
        assign btn_db[i] = db;
        assign step[i]   = stp;
    end

    // Opposing steps cancel; down-step sum is formed one bit wider so it cannot wrap.
    function automatic logic [Y_W-1:0] next_y(input logic [Y_W-1:0] y, input logic up, input logic dn);
        next_y = (up == dn) ? y
               : up ? ((y < STEP_Y) ? '0 : y - STEP_Y)
               : (({1'b0, y} + {1'b0, STEP_Y} > {1'b0, Y_TOP}) ? Y_TOP : y + STEP_Y);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || recenter) begin
            p1_y <= CENTER;
            p2_y <= CENTER;
        end else begin
            p1_y <= next_y(p1_y, step[0], step[1]);
            p2_y <= next_y(p2_y, step[2], step[3]);
        end
    end
endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl: directed bench for paddle_input_ctrl with small timing parameters
module tb_paddle_input_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn_raw;
    logic        enable;
    logic        recenter;
    logic [3:0]  btn_db;
    logic [3:0]  step;
    logic [10:0] p1_y;
    logic [10:0] p2_y;

    int checks = 0;
    int errors = 0;
    int ey1, ey2;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] db;
        logic [3:0] st;
        int         y1;
        int         y2;
    } vec_t;

    vec_t tbl[16];

    paddle_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3),
        .STEP(8),
        .Y_MAX(100),
        .PADDLE_H(20),
        .Y_W(11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .enable(enable),
        .recenter(recenter),
        .btn_db(btn_db),
        .step(step),
        .p1_y(p1_y),
        .p2_y(p2_y)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mv(input int y, input logic up, input logic dn);
        if (up == dn) return y;
        if (up) return (y < 8) ? 0 : y - 8;
        return (y + 8 > 80) ? 80 : y + 8;
    endfunction

    // Hold mask m for n ticks then release for rel ticks; rc_at > 0 pulses recenter before that tick.
    // Expected steps: 7 ticks after press, then 10 later, then every 3, until the release is debounced.
    task automatic run_hold(input logic [3:0] m, input int n, input int rel, input int rc_at);
        logic [3:0] pend = '0;
        for (int c = 1; c <= n + rel; c++) begin
            btn_raw  = (c <= n) ? m : 4'b0000;
            recenter = (c == rc_at);
            tick;
            if (c == rc_at) begin
                ey1 = 40;
                ey2 = 40;
            end else begin
                ey1 = mv(ey1, pend[0], pend[1]);
                ey2 = mv(ey2, pend[2], pend[3]);
            end
            pend = ((c == 7 || (c >= 17 && (c - 17) % 3 == 0)) && c <= n + 6) ? m : 4'b0000;
            chk("hold_step", step, pend);
            chk("hold_p1_y", p1_y, ey1);
            chk("hold_p2_y", p2_y, ey2);
        end
        recenter = 1'b0;
    endtask

    initial begin
        for (int j = 0; j < 16; j++)
            tbl[j] = '{raw: (j < 8) ? 4'b0001 : 4'b0000,
                       db:  (j >= 5 && j <= 12) ? 4'b0001 : 4'b0000,
                       st:  (j == 6) ? 4'b0001 : 4'b0000,
                       y1:  (j >= 7) ? 32 : 40,
                       y2:  40};

        rst = 1'b1; btn_raw = '0; enable = 1'b0; recenter = 1'b0;
        tick;
        tick;
        chk("rst_p1_y", p1_y, 40);
        chk("rst_p2_y", p2_y, 40);
        chk("rst_btn_db", btn_db, 0);
        chk("rst_step", step, 0);
        rst = 1'b0;
        enable = 1'b1;

        for (int j = 0; j < 16; j++) begin
            btn_raw = tbl[j].raw;
            tick;
            chk("vec_btn_db", btn_db, tbl[j].db);
            chk("vec_step", step, tbl[j].st);
            chk("vec_p1_y", p1_y, tbl[j].y1);
            chk("vec_p2_y", p2_y, tbl[j].y2);
        end
        ey1 = 32;
        ey2 = 40;

        for (int c = 0; c < 9; c++) begin
            btn_raw = (c < 3) ? 4'b0010 : 4'b0000;
            tick;
            chk("glitch_btn_db", btn_db, 0);
            chk("glitch_step", step, 0);
            chk("glitch_p1_y", p1_y, 32);
        end

        run_hold(4'b1000, 30, 0, 0);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_p1_y", p1_y, 40);
        chk("midrst_p2_y", p2_y, 40);
        chk("midrst_btn_db", btn_db, 0);
        chk("midrst_step", step, 0);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("postrst_step", step, 0);
        end
        btn_raw = '0;
        repeat (6) tick;
        chk("postrst_btn_db", btn_db, 0);
        ey1 = 40;
        ey2 = 40;

        run_hold(4'b0001, 30, 8, 0);
        chk("clamp_top_p1_y", p1_y, 0);

        recenter = 1'b1;
        tick;
        recenter = 1'b0;
        chk("recenter_p1_y", p1_y, 40);
        chk("recenter_p2_y", p2_y, 40);
        ey1 = 40;
        ey2 = 40;

        run_hold(4'b0011, 10, 8, 0);
        chk("conflict_p1_y", p1_y, 40);

        run_hold(4'b0010, 22, 8, 18);

        recenter = 1'b1;
        tick;
        recenter = 1'b0;
        chk("recenter2_p1_y", p1_y, 40);
        ey1 = 40;

        enable = 1'b0;
        btn_raw = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            tick;
            chk("dis_step", step, 0);
        end
        chk("dis_btn_db", btn_db, 4'b0100);
        chk("dis_p2_y", p2_y, 40);
        enable = 1'b1;
        tick;
        chk("en_step", step, 4'b0100);
        tick;
        chk("en_step_off", step, 0);
        chk("en_p2_y", p2_y, 32);
        chk("en_p1_y", p1_y, 40);
        enable = 1'b0;
        btn_raw = '0;
        repeat (8) tick;
        chk("end_btn_db", btn_db, 0);
        chk("end_p2_y", p2_y, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
